// File: rtl/ram_pkg.sv
// Shared types and presets for the parametrised data RAM family.
// Read-path option macro: RAM_PARAM_RDREG_EN (see ram_param).
package ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ram_state_e;

  localparam int RAM_DEFAULT_WIDTH  = 16;
  localparam int RAM_DEFAULT_ADDR_W = 14;
  localparam int RAM16K_ADDR_W      = 14;
  localparam int RAM8_ADDR_W        = 3;

  function automatic int ram_depth(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks ptr over every word once after reset or on request,
// raising busy for the whole sweep.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic [ADDR_W-1:0] ptr,
  output logic              clr_we,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  ram_state_e        state_r;
  ram_state_e        state_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_s;

  // Next-state and pointer sequencing; clear is ignored while sweeping.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (clear) begin
          state_s = ST_CLEAR;
          ptr_s   = {ADDR_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (ptr_r == PTR_LAST) begin
          state_s = ST_IDLE;
          ptr_s   = {ADDR_W{1'b0}};
        end else begin
          ptr_s = ptr_r + ADDR_W'(1);
        end
      end
      default: begin
        state_s = ST_CLEAR;
        ptr_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State and pointer registers; reset starts a fresh sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      ptr_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
    end
  end

  assign busy   = (state_r == ST_CLEAR);
  assign clr_we = busy;
  assign ptr    = ptr_r;

endmodule

// File: rtl/ram_param.sv
// WIDTH x 2**ADDR_W single-port RAM with Hack RAM semantics and a zero-fill engine.
// Define RAM_PARAM_RDREG_EN for a registered (read-before-write) output.
module ram_param
  import ram_pkg::*;
#(
  parameter int               WIDTH     = RAM_DEFAULT_WIDTH,
  parameter int               ADDR_W    = RAM_DEFAULT_ADDR_W,
  parameter logic [WIDTH-1:0] CLEAR_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = ram_depth(ADDR_W);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [ADDR_W-1:0] ptr_s;
  logic              clr_we_s;
  logic              busy_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [WIDTH-1:0]  wdata_s;

  ram_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .ptr    (ptr_s),
    .clr_we (clr_we_s),
    .busy   (busy_s)
  );

  // Write-port mux: the clear engine owns the port while busy.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = address;
    wdata_s = in;
    if (busy_s) begin
      we_s    = clr_we_s;
      waddr_s = ptr_s;
      wdata_s = CLEAR_VAL;
    end else begin
      we_s = load;
    end
  end

  // Storage array; intentionally not reset, the clear engine initialises it.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

`ifdef RAM_PARAM_RDREG_EN
  logic [WIDTH-1:0] out_r;

  // Registered read; samples the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= CLEAR_VAL;
    end else begin
      out_r <= busy_s ? CLEAR_VAL : mem_r[address];
    end
  end

  assign out = out_r;
`else
  assign out = busy_s ? CLEAR_VAL : mem_r[address];
`endif

  assign busy = busy_s;

endmodule

// File: tb/tb_ram_param.sv
// Randomised self-checking bench for ram_param (ADDR_W=4, WIDTH=16) against
// a word-array reference model with a remaining-clear-cycles counter.
module tb_ram_param;

  localparam int W     = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in = '0;
  logic [AW-1:0] address = '0;
  logic          load = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  out;
  logic          busy;

  ram_param #(.WIDTH(W), .ADDR_W(AW), .CLEAR_VAL(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .address(address),
    .load(load), .clear(clear), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference model
  logic [W-1:0] m_mem [DEPTH];
  int           m_rem = DEPTH;
  logic [W-1:0] m_out_r = 16'h0000;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_out();
`ifdef RAM_PARAM_RDREG_EN
    return m_out_r;
`else
    return (m_rem > 0) ? 16'h0000 : m_mem[address];
`endif
  endfunction

  // One clock: apply inputs, advance model at posedge, check at negedge.
  task automatic cyc(input logic ld, input logic [AW-1:0] a, input logic [W-1:0] d,
                     input logic cl, input string tag);
    load = ld; address = a; in = d; clear = cl;
    @(posedge clk);
    if (!rst_n) begin
      m_rem   = DEPTH;
      m_out_r = 16'h0000;
    end else begin
      m_out_r = (m_rem > 0) ? 16'h0000 : m_mem[a];
      if (m_rem > 0) begin
        m_mem[DEPTH - m_rem] = 16'h0000;
        m_rem--;
      end else begin
        if (ld) m_mem[a] = d;
        if (cl) m_rem = DEPTH;
      end
    end
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (m_rem > 0)});
    chk({tag, "_out"}, {16'd0, out}, {16'd0, exp_out()});
  endtask

  // Count edges until busy drops, driving optional mid-sweep clear pulse.
  task automatic measure_busy(input int pulse_at, output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      cyc(1'b1, AW'($urandom_range(0, DEPTH-1)), W'($urandom), (n == pulse_at), "sweep");
      n++;
    end
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;

    // power-up reset held two cycles
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_out", {16'd0, out}, 32'd0);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, "rst");
    cyc(1'b0, 4'd0, 16'h0, 1'b0, "rst");
    rst_n = 1'b1;
    measure_busy(-1, n);
    chk("powerup_len", n, 32'd16);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, AW'(i), 16'h0, 1'b0, "pu_read");

    // basic write/read
    cyc(1'b1, 4'd1, 16'hAAAA, 1'b0, "wr1");
    cyc(1'b0, 4'd1, 16'h0, 1'b0, "rd1");
    cyc(1'b0, 4'd1, 16'h0, 1'b0, "rd1b");
    chk("rd1_val", {16'd0, out}, 32'h0000AAAA);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, "rd0");
    cyc(1'b0, 4'd0, 16'h0, 1'b0, "rd0b");
    chk("rd0_val", {16'd0, out}, 32'h00000000);

    // requested clear after writes to 3 and 15
    cyc(1'b1, 4'd3, 16'hBEEF, 1'b0, "wr3");
    cyc(1'b1, 4'd15, 16'hBEEF, 1'b0, "wr15");
    cyc(1'b0, 4'd15, 16'h0, 1'b0, "rd15");
    cyc(1'b0, 4'd15, 16'h0, 1'b1, "clr");
    measure_busy(-1, n);
    chk("clear_len", n, 32'd16);
    cyc(1'b0, 4'd3, 16'h0, 1'b0, "rd3c");
    cyc(1'b0, 4'd15, 16'h0, 1'b0, "rd15c");

    // blocked write during busy: address 5
    cyc(1'b0, 4'd5, 16'h0, 1'b1, "clr2");
    cyc(1'b1, 4'd5, 16'h1234, 1'b0, "blk");
    measure_busy(-1, n);
    chk("blk_len", n, 32'd15);
    cyc(1'b0, 4'd5, 16'h0, 1'b0, "rd5");
    cyc(1'b0, 4'd5, 16'h0, 1'b0, "rd5b");
    chk("rd5_val", {16'd0, out}, 32'd0);

    // simultaneous load+clear, then re-trigger mid-sweep
    cyc(1'b1, 4'd2, 16'h5555, 1'b1, "ldclr");
    measure_busy(7, n);
    chk("retrig_len", n, 32'd16);
    cyc(1'b0, 4'd2, 16'h0, 1'b0, "rd2");
    cyc(1'b0, 4'd2, 16'h0, 1'b0, "rd2b");
    chk("rd2_val", {16'd0, out}, 32'd0);

    // randomised traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      a = AW'($urandom_range(0, DEPTH-1));
      cyc(1'($urandom_range(0, 1)), a, W'($urandom), ($urandom_range(0, 39) == 0), "rand");
    end
    while (m_rem > 0) cyc(1'b0, 4'd0, 16'h0, 1'b0, "drain");

    // reset in the middle of a sweep
    cyc(1'b1, 4'd9, 16'hC3C3, 1'b0, "wr9");
    cyc(1'b0, 4'd9, 16'h0, 1'b1, "clr3");
    for (int i = 0; i < 7; i++) cyc(1'b0, 4'd9, 16'h0, 1'b0, "pre_rst");
    #2 rst_n = 1'b0;
    m_rem = DEPTH; m_out_r = 16'h0000;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_out", {16'd0, out}, 32'd0);
    @(negedge clk);
    cyc(1'b0, 4'd9, 16'h0, 1'b0, "in_rst");
    rst_n = 1'b1;
    measure_busy(-1, n);
    chk("midrst_len", n, 32'd16);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, AW'(i), 16'h0, 1'b0, "post_read");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
